// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Serialises instruction-cache line fills and data-cache loads/stores onto a
// single main-memory request port. Each access is issued as a one-cycle
// mem_req pulse. The arbiter then waits for mem_response_valid, or declares the
// fill lost after TIMEOUT_CYCLES wait cycles. The returned line is flagged
// valid only for the client that owns the outstanding access.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   ic_req / ic_addr      icache fill request (level, held until ic_fill_valid)
//   ic_fill_data/_valid   line returned to icache (valid is a one-cycle pulse)
//   dc_req / dc_store / dc_store_word / dc_addr / dc_store_data
//                         dcache request (level, held until fill_valid or
//                         store_done); store_word=0 means a byte store
//   dc_fill_data/_valid   line returned to dcache (valid is a one-cycle pulse)
//   dc_store_done         one-cycle pulse when a store is committed
//   mem_req, mem_store, mem_store_word, mem_address, mem_evict_data
//                         request port towards memory
//   mem_fill_data, mem_response_valid
//                         response port from memory
//   timeout_err           sticky flag, set when a fill is declared lost
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int FILL_DATA_WIDTH = 128,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int WORD_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  // icache client
  input  logic                       ic_req,
  input  logic [ADDRESS_WIDTH-1:0]   ic_addr,
  output logic [FILL_DATA_WIDTH-1:0] ic_fill_data,
  output logic                       ic_fill_valid,
  // dcache client
  input  logic                       dc_req,
  input  logic                       dc_store,
  input  logic                       dc_store_word,
  input  logic [ADDRESS_WIDTH-1:0]   dc_addr,
  input  logic [WORD_WIDTH-1:0]      dc_store_data,
  output logic [FILL_DATA_WIDTH-1:0] dc_fill_data,
  output logic                       dc_fill_valid,
  output logic                       dc_store_done,
  // memory port
  output logic                       mem_req,
  output logic                       mem_store,
  output logic                       mem_store_word,
  output logic [ADDRESS_WIDTH-1:0]   mem_address,
  output logic [WORD_WIDTH-1:0]      mem_evict_data,
  input  logic [FILL_DATA_WIDTH-1:0] mem_fill_data,
  input  logic                       mem_response_valid,
  // status
  output logic                       timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  typedef enum logic {
    OWN_IC,
    OWN_DC
  } owner_e;

  state_e                   state_q, state_d;
  owner_e                   owner_q, owner_d;
  owner_e                   last_grant_q, last_grant_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     store_q, store_d;
  logic                     store_word_q, store_word_d;
  logic [WORD_WIDTH-1:0]    data_q, data_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     timeout_err_q, timeout_err_d;

  logic grant_dc;
  logic fill_fire;   // owner's fill completes this cycle
  logic fill_lost;   // ...and it completes because of the timeout
  logic store_fire;

  // ---------------------------------------------------------------------------
  // Next-state and pulse logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can infer a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    store_d       = store_q;
    store_word_d  = store_word_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    grant_dc      = 1'b0;
    fill_fire     = 1'b0;
    fill_lost     = 1'b0;
    store_fire    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ic_req || dc_req) begin
          if (ic_req && dc_req) begin
            // Conflict: favour the client that did not win the previous
            // conflict. Uncontested grants leave last_grant untouched.
            grant_dc     = (last_grant_q == OWN_IC);
            last_grant_d = grant_dc ? OWN_DC : OWN_IC;
          end else begin
            grant_dc = dc_req;
          end

          if (grant_dc) begin
            owner_d      = OWN_DC;
            addr_d       = dc_addr;
            store_d      = dc_store;
            store_word_d = dc_store_word;
            data_d       = dc_store_data;
          end else begin
            // The icache only ever fills.
            owner_d      = OWN_IC;
            addr_d       = ic_addr;
            store_d      = 1'b0;
            store_word_d = 1'b0;
            data_d       = '0;
          end
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (store_q) begin
          // The write commits with this mem_req pulse; nothing comes back.
          store_fire = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_response_valid) begin
          fill_fire = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fill_fire     = 1'b1;
          fill_lost     = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before this edge.
    if (reset) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_IC;
      last_grant_q  <= OWN_IC;
      addr_q        <= '0;
      store_q       <= 1'b0;
      store_word_q  <= 1'b0;
      data_q        <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      addr_q        <= addr_d;
      store_q       <= store_d;
      store_word_q  <= store_word_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req        = (state_q == S_ISSUE);
  assign mem_store      = store_q;
  assign mem_store_word = store_word_q;
  assign mem_address    = addr_q;
  assign mem_evict_data = data_q;

  assign ic_fill_valid  = fill_fire && (owner_q == OWN_IC);
  assign dc_fill_valid  = fill_fire && (owner_q == OWN_DC);
  assign dc_store_done  = store_fire;

  // A lost fill hands its owner an all-zero line instead of whatever happens
  // to be on the memory data bus.
  assign ic_fill_data   = (fill_lost && (owner_q == OWN_IC)) ? '0 : mem_fill_data;
  assign dc_fill_data   = (fill_lost && (owner_q == OWN_DC)) ? '0 : mem_fill_data;

  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives both cache clients and a behavioural main memory (fixed response
// latency, optional mute) around mem_arbiter. Expected grant order, completion
// cycles and returned lines come from an arrival-time arbitration model and a
// byte-addressed reference memory kept in this file.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int FDW = 128;
  localparam int AW  = 32;
  localparam int WW  = 32;
  localparam int TO  = 16;
  localparam int DLY = 5;
  localparam int BIG = 1 << 30;

  logic           clk = 1'b0;
  logic           reset;
  logic           ic_req, dc_req, dc_store, dc_store_word;
  logic [AW-1:0]  ic_addr, dc_addr, mem_address;
  logic [WW-1:0]  dc_store_data, mem_evict_data;
  logic [FDW-1:0] ic_fill_data, dc_fill_data, mem_fill_data;
  logic           ic_fill_valid, dc_fill_valid, dc_store_done;
  logic           mem_req, mem_store, mem_store_word, mem_response_valid;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit m_last_dc = 1'b0;   // model: last conflict was won by the dcache

  mem_arbiter #(
    .FILL_DATA_WIDTH(FDW), .ADDRESS_WIDTH(AW), .WORD_WIDTH(WW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_fill_data(ic_fill_data), .ic_fill_valid(ic_fill_valid),
    .dc_req(dc_req), .dc_store(dc_store), .dc_store_word(dc_store_word), .dc_addr(dc_addr),
    .dc_store_data(dc_store_data), .dc_fill_data(dc_fill_data), .dc_fill_valid(dc_fill_valid),
    .dc_store_done(dc_store_done),
    .mem_req(mem_req), .mem_store(mem_store), .mem_store_word(mem_store_word),
    .mem_address(mem_address), .mem_evict_data(mem_evict_data), .mem_fill_data(mem_fill_data),
    .mem_response_valid(mem_response_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Behavioural main memory: 16-byte lines, responds DLY cycles after mem_req
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] init_byte(int a);
    return 8'((a * 29 + 113) ^ (a >>> 3));
  endfunction

  logic [FDW-1:0] mem_lines [int];
  bit             mem_mute = 1'b0;
  int             pend_cnt = 0;
  int             pend_idx = 0;
  int             st_cnt = 0;
  logic [AW-1:0]  st_addr;
  logic [WW-1:0]  st_data;
  logic           st_word;

  function automatic logic [FDW-1:0] rd_line(int idx);
    logic [FDW-1:0] l;
    if (mem_lines.exists(idx)) return mem_lines[idx];
    for (int i = 0; i < 16; i++) l[8*i +: 8] = init_byte(idx * 16 + i);
    return l;
  endfunction

  always @(posedge clk) begin
    logic [FDW-1:0] l;
    int idx;
    #1;
    mem_response_valid = 1'b0;
    mem_fill_data      = {$urandom, $urandom, $urandom, $urandom | 32'h1};
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_response_valid = 1'b1;
        mem_fill_data      = rd_line(pend_idx);
      end
    end
    if (mem_req) begin
      idx = int'(mem_address >> 4);
      if (mem_store) begin
        l = rd_line(idx);
        if (mem_store_word) l[32*int'(mem_address[3:2]) +: 32] = mem_evict_data;
        else                l[8*int'(mem_address[3:0]) +: 8]   = mem_evict_data[7:0];
        mem_lines[idx] = l;
        st_cnt++;
        st_addr = mem_address;
        st_data = mem_evict_data;
        st_word = mem_store_word;
      end else if (!mem_mute) begin
        pend_cnt = DLY;
        pend_idx = idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference byte memory
  // ---------------------------------------------------------------------------
  logic [7:0] ref_bytes [int];

  function automatic logic [7:0] ref_rd(int a);
    return ref_bytes.exists(a) ? ref_bytes[a] : init_byte(a);
  endfunction

  function automatic logic [FDW-1:0] ref_line(logic [AW-1:0] addr);
    logic [FDW-1:0] l;
    int base;
    base = int'(addr) & ~15;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = ref_rd(base + i);
    return l;
  endfunction

  function automatic void ref_store(logic [AW-1:0] addr, logic [WW-1:0] d, bit word);
    int a;
    a = int'(addr);
    if (word) for (int k = 0; k < 4; k++) ref_bytes[(a & ~3) + k] = d[8*k +: 8];
    else ref_bytes[a] = d[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Bus monitor: mem_req cycles, back-to-back mem_req, pulses without a request
  // ---------------------------------------------------------------------------
  int req_q[$];
  int dbl_cnt  = 0;
  int spur_cnt = 0;
  bit prev_req = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req) begin
        req_q.push_back(cyc);
        if (prev_req) dbl_cnt++;
      end
      if (ic_fill_valid && !ic_req) spur_cnt++;
      if ((dc_fill_valid || dc_store_done) && !dc_req) spur_cnt++;
      if (dc_fill_valid && dc_store_done) spur_cnt++;
    end
    prev_req = mem_req;
  end

  // ---------------------------------------------------------------------------
  // Client drivers
  // ---------------------------------------------------------------------------
  task automatic ic_client(input int dly, input logic [AW-1:0] a,
                           output int done, output logic [FDW-1:0] d);
    repeat (dly) begin @(posedge clk); #2; end
    ic_addr = a;
    ic_req  = 1'b1;
    done    = -1;
    d       = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ic_fill_valid) begin done = cyc; d = ic_fill_data; break; end
    end
    @(posedge clk); #2;
    ic_req = 1'b0;
  endtask

  task automatic dc_client(input int op, input logic [AW-1:0] a, input logic [WW-1:0] sd,
                           output int done, output bit was_store, output logic [FDW-1:0] d);
    dc_addr       = a;
    dc_store      = (op != 0);
    dc_store_word = (op == 1);
    dc_store_data = sd;
    dc_req        = 1'b1;
    done          = -1;
    was_store     = 1'b0;
    d             = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dc_fill_valid || dc_store_done) begin
        done = cyc; was_store = dc_store_done; d = dc_fill_data; break;
      end
    end
    @(posedge clk); #2;
    dc_req = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // One round: optional IC fill (arriving ic_dly cycles late) and optional DC
  // access (op 0 fill, 1 word store, 2 byte store), starting with the arbiter
  // idle. Predicts grant order, completion cycles and data, then compares.
  // ---------------------------------------------------------------------------
  task automatic run_round(input string name, input bit has_ic, input bit has_dc,
                           input int ic_dly, input int op,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic [WW-1:0] sd,
                           output int t0, output int ic_done, output int dc_done,
                           output logic [FDW-1:0] ic_d, output logic [FDW-1:0] dc_d);
    int ic_arr, dc_arr, ic_lat, dc_lat, g1, d1, g2, d2, sec_arr;
    int n_req, n_dbl, n_spur, n_st, exp_ic_done, exp_dc_done, exp_st;
    int exp_req[$];
    bit dc_first, dc_st, serve_dc, req_ok;
    logic [FDW-1:0] exp_ic_d, exp_dc_d;

    @(posedge clk); #2;
    t0 = cyc;
    n_req = req_q.size(); n_dbl = dbl_cnt; n_spur = spur_cnt; n_st = st_cnt;
    ic_done = -1; dc_done = -1; ic_d = '0; dc_d = '0; dc_st = 1'b0;
    exp_ic_d = '0; exp_dc_d = '0; d2 = -1;

    // Arbitration model: a grant happens at the later of arrival and idle.
    ic_arr = has_ic ? t0 + ic_dly : BIG;
    dc_arr = has_dc ? t0 : BIG;
    ic_lat = 1 + DLY;
    dc_lat = (op == 0) ? 1 + DLY : 1;
    if (ic_arr == dc_arr) begin
      dc_first  = !m_last_dc;
      m_last_dc = dc_first;
    end else begin
      dc_first = (dc_arr < ic_arr);
    end
    g1 = dc_first ? dc_arr : ic_arr;
    d1 = g1 + (dc_first ? dc_lat : ic_lat);
    exp_req.push_back(g1 + 1);
    if (has_ic && has_dc) begin
      sec_arr = dc_first ? ic_arr : dc_arr;
      g2 = (sec_arr > d1 + 1) ? sec_arr : d1 + 1;
      d2 = g2 + (dc_first ? ic_lat : dc_lat);
      exp_req.push_back(g2 + 1);
    end
    exp_ic_done = dc_first ? d2 : d1;
    exp_dc_done = dc_first ? d1 : d2;
    for (int k = 0; k < 2; k++) begin
      if (k == 1 && !(has_ic && has_dc)) break;
      serve_dc = (k == 0) ? dc_first : !dc_first;
      if (serve_dc) begin
        if (op == 0) exp_dc_d = ref_line(da);
        else ref_store(da, sd, op == 1);
      end else begin
        exp_ic_d = ref_line(ia);
      end
    end
    exp_st = (has_dc && op != 0) ? 1 : 0;

    fork
      begin if (has_ic) ic_client(ic_dly, ia, ic_done, ic_d); end
      begin if (has_dc) dc_client(op, da, sd, dc_done, dc_st, dc_d); end
    join

    if (has_ic) begin
      checks++;
      if (ic_done !== exp_ic_done) begin
        errors++; $display("FAIL %s ic_done got %0d exp %0d", name, ic_done, exp_ic_done);
      end
      checks++;
      if (ic_d !== exp_ic_d) begin
        errors++; $display("FAIL %s ic_fill_data got %h exp %h", name, ic_d, exp_ic_d);
      end
    end
    if (has_dc) begin
      checks++;
      if (dc_done !== exp_dc_done || dc_st !== (op != 0)) begin
        errors++;
        $display("FAIL %s dc_done got %0d/store=%0b exp %0d/store=%0b",
                 name, dc_done, dc_st, exp_dc_done, (op != 0));
      end
      if (op == 0) begin
        checks++;
        if (dc_d !== exp_dc_d) begin
          errors++; $display("FAIL %s dc_fill_data got %h exp %h", name, dc_d, exp_dc_d);
        end
      end
    end
    checks++;
    req_ok = (req_q.size() - n_req == exp_req.size());
    if (req_ok) foreach (exp_req[i]) if (req_q[n_req + i] != exp_req[i]) req_ok = 1'b0;
    if (!req_ok) begin
      errors++;
      $display("FAIL %s mem_req cycles got %0d pulses (first %0d) exp %0d pulses (first %0d)",
               name, req_q.size() - n_req, (req_q.size() > n_req) ? req_q[n_req] : -1,
               exp_req.size(), exp_req[0]);
    end
    checks++;
    if (dbl_cnt != n_dbl || spur_cnt != n_spur) begin
      errors++;
      $display("FAIL %s protocol got %0d double-req %0d stray-pulse exp 0 0",
               name, dbl_cnt - n_dbl, spur_cnt - n_spur);
    end
    checks++;
    if (st_cnt - n_st != exp_st) begin
      errors++; $display("FAIL %s store_count got %0d exp %0d", name, st_cnt - n_st, exp_st);
    end else if (exp_st == 1 && (st_addr !== da || st_data !== sd || st_word !== (op == 1))) begin
      errors++;
      $display("FAIL %s store_fields got %h/%h/%0b exp %h/%h/%0b",
               name, st_addr, st_data, st_word, da, sd, (op == 1));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, ic_fill_valid, dc_fill_valid, dc_store_done, timeout_err,
         mem_store, mem_store_word} !== 7'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b exp 0000000", {mem_req, ic_fill_valid, dc_fill_valid,
               dc_store_done, timeout_err, mem_store, mem_store_word});
    end
    checks++;
    if (mem_address !== '0 || mem_evict_data !== '0) begin
      errors++;
      $display("FAIL reset_latched got %h/%h exp 0/0", mem_address, mem_evict_data);
    end
    @(posedge clk); #2;
    reset     = 1'b0;
    m_last_dc = 1'b0;
  endtask

  task automatic test_ic_fill;
    int t0, icd, dcd;
    logic [FDW-1:0] icl, dcl, p;
    p = ref_line(32'h40);
    run_round("ic_fill", 1'b1, 1'b0, 0, 0, 32'h40, '0, '0, t0, icd, dcd, icl, dcl);
    checks++;
    if (icd !== t0 + 6 || icl !== p) begin
      errors++; $display("FAIL ic_fill_latency got %0d/%h exp %0d/%h", icd - t0, icl, 6, p);
    end
  endtask

  task automatic test_dc_store_fill;
    int t0, icd, dcd;
    logic [FDW-1:0] icl, dcl;
    run_round("dc_word_store", 1'b0, 1'b1, 0, 1, '0, 32'h10, 32'hDEADBEEF, t0, icd, dcd, icl, dcl);
    checks++;
    if (dcd !== t0 + 1) begin
      errors++; $display("FAIL store_latency got %0d exp 1", dcd - t0);
    end
    run_round("dc_fill_after_word", 1'b0, 1'b1, 0, 0, '0, 32'h10, '0, t0, icd, dcd, icl, dcl);
    checks++;
    if (dcl[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_readback got %h exp deadbeef", dcl[31:0]);
    end
    run_round("dc_byte_store", 1'b0, 1'b1, 0, 2, '0, 32'h11, 32'h123456AB, t0, icd, dcd, icl, dcl);
    run_round("dc_fill_after_byte", 1'b0, 1'b1, 0, 0, '0, 32'h10, '0, t0, icd, dcd, icl, dcl);
    checks++;
    if (dcl[31:0] !== 32'hDEADABEF) begin
      errors++; $display("FAIL byte_readback got %h exp deadabef", dcl[31:0]);
    end
  endtask

  task automatic test_arbitration;
    int t0, icd, dcd;
    logic [FDW-1:0] icl, dcl;
    run_round("conflict1", 1'b1, 1'b1, 0, 0, 32'h40, 32'h80, '0, t0, icd, dcd, icl, dcl);
    checks++;
    if (dcd !== t0 + 6 || icd !== t0 + 13) begin
      errors++; $display("FAIL conflict1_order got dc %0d ic %0d exp dc 6 ic 13", dcd - t0, icd - t0);
    end
    run_round("conflict2", 1'b1, 1'b1, 0, 0, 32'h50, 32'h90, '0, t0, icd, dcd, icl, dcl);
    checks++;
    if (icd !== t0 + 6 || dcd !== t0 + 13) begin
      errors++; $display("FAIL conflict2_order got ic %0d dc %0d exp ic 6 dc 13", icd - t0, dcd - t0);
    end
  endtask

  task automatic test_back_to_back;
    int t0, icd, dcd, n0;
    logic [FDW-1:0] icl, dcl;
    n0 = req_q.size();
    run_round("ic_during_wait", 1'b1, 1'b1, 2, 0, 32'h24, 32'h68, '0, t0, icd, dcd, icl, dcl);
    checks++;
    if (dcd !== t0 + 6 || icd !== t0 + 13 || req_q.size() != n0 + 2 || req_q[n0 + 1] != dcd + 2) begin
      errors++;
      $display("FAIL ic_during_wait got dc %0d ic %0d exp dc 6 ic 13, second mem_req at dc+2",
               dcd - t0, icd - t0);
    end
  endtask

  task automatic test_timeout;
    int t0, done, n0, icd, dcd;
    logic [FDW-1:0] d, icl, dcl;
    mem_mute = 1'b1;
    @(posedge clk); #2;
    t0 = cyc;
    n0 = req_q.size();
    ic_client(0, 32'h20, done, d);
    checks++;
    if (done !== t0 + 1 + TO) begin
      errors++; $display("FAIL timeout_latency got %0d exp %0d", done - t0, 1 + TO);
    end
    checks++;
    if (d !== '0) begin
      errors++; $display("FAIL timeout_data got %h exp 0", d);
    end
    checks++;
    if (req_q.size() != n0 + 1) begin
      errors++; $display("FAIL timeout_reqs got %0d exp 1", req_q.size() - n0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b1) begin
        errors++; $display("FAIL timeout_err_hold got %b exp 1", timeout_err);
      end
    end
    mem_mute = 1'b0;
    run_round("after_timeout", 1'b0, 1'b1, 0, 0, '0, 32'h30, '0, t0, icd, dcd, icl, dcl);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_err_sticky got %b exp 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid_wait;
    @(posedge clk); #2;
    ic_addr = 32'h44;
    ic_req  = 1'b1;
    // ISSUE in the next cycle, memory answers five cycles after that
    repeat (4) @(posedge clk);
    #2;
    reset  = 1'b1;
    ic_req = 1'b0;
    @(posedge clk); #2;
    reset     = 1'b0;
    m_last_dc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, ic_fill_valid, dc_fill_valid, dc_store_done, timeout_err,
           mem_store, mem_store_word} !== 7'b0 || mem_address !== '0) begin
        errors++;
        $display("FAIL reset_mid_wait cycle %0d got %b/%h exp 0000000/0", i,
                 {mem_req, ic_fill_valid, dc_fill_valid, dc_store_done, timeout_err,
                  mem_store, mem_store_word}, mem_address);
      end
    end
  endtask

  task automatic test_random;
    int t0, icd, dcd, kind, op, dly;
    bit hi, hd;
    logic [FDW-1:0] icl, dcl;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      hi   = (kind != 1);
      hd   = (kind != 0);
      dly  = (hi && hd) ? $urandom_range(0, 3) : 0;
      op   = $urandom_range(0, 2);
      run_round($sformatf("rand%0d", i), hi, hd, dly, op,
                AW'($urandom_range(0, 127)), AW'($urandom_range(0, 127)), WW'($urandom),
                t0, icd, dcd, icl, dcl);
    end
  endtask

  initial begin
    reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_store = 1'b0; dc_store_word = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_store_data = '0;
    test_reset();
    test_ic_fill();
    test_dc_store_fill();
    test_arbitration();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
